// File: rtl/eightbit_deserializer.sv
// Serial-in, parallel-out word receiver with start-strobe framing,
// valid/ready holding register and sticky overrun / frame-restart flags.
module eightbit_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             serial_valid,
   input  logic             frame_start,
   input  logic             dir,
   input  logic             clr_flags,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             overrun,
   output logic             frame_err
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic             dir_q;
   logic             dir_sel;
   logic [WIDTH-1:0] pout_q;
   logic             ovalid_q;
   logic             ovr_q;
   logic             ferr_q;

   // A start beat uses the direction presented with it, not the latched one
   always_comb begin
      dir_sel = frame_start ? dir : dir_q;
      shreg_d = '0;
      if (dir_sel)
         shreg_d = {serial_in, shreg_q[WIDTH-1:1]};
      else
         shreg_d = {shreg_q[WIDTH-2:0], serial_in};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shreg_q  <= '0;
         dir_q    <= 1'b0;
         pout_q   <= '0;
         ovalid_q <= 1'b0;
         ovr_q    <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         if (ovalid_q && out_ready)
            ovalid_q <= 1'b0;
         if (clr_flags) begin
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (serial_valid && frame_start) begin
                  dir_q   <= dir;
                  shreg_q <= shreg_d;
                  cnt_q   <= CW'(1);
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (serial_valid && frame_start) begin
                  ferr_q  <= 1'b1;
                  dir_q   <= dir;
                  shreg_q <= shreg_d;
                  cnt_q   <= CW'(1);
               end else if (serial_valid) begin
                  shreg_q <= shreg_d;
                  if (cnt_q == CW'(WIDTH-1)) begin
                     cnt_q   <= '0;
                     state_q <= IDLE;
                     if (ovalid_q && !out_ready) begin
                        ovr_q <= 1'b1;
                     end else begin
                        pout_q   <= shreg_d;
                        ovalid_q <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign parallel_out = pout_q;
   assign out_valid    = ovalid_q;
   assign overrun      = ovr_q;
   assign frame_err    = ferr_q;
   assign busy         = (state_q == SHIFT);

endmodule

// File: tb/tb_eightbit_deserializer.sv
// Randomized + directed bench for eightbit_deserializer against a
// bit-queue reference model of the framing and holding-register rules.
module tb_eightbit_deserializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         serial_in = 1'b0;
   logic         serial_valid = 1'b0;
   logic         frame_start = 1'b0;
   logic         dir = 1'b0;
   logic         clr_flags = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] parallel_out;
   logic         out_valid;
   logic         busy;
   logic         overrun;
   logic         frame_err;

   eightbit_deserializer #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .serial_valid (serial_valid),
      .frame_start  (frame_start),
      .dir          (dir),
      .clr_flags    (clr_flags),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .busy         (busy),
      .overrun      (overrun),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   bit           mq[$];
   bit           m_in = 0;
   bit           m_dir = 0;
   logic [W-1:0] m_pout = '0;
   bit           m_v = 0;
   bit           m_ov = 0;
   bit           m_fe = 0;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] assemble(input bit lsb_first);
      logic [W-1:0] w = '0;
      for (int i = 0; i < W; i++)
         if (lsb_first) w[i] = mq[i];
         else           w[W-1-i] = mq[i];
      return w;
   endfunction

   task automatic model_edge();
      bit nv, nov, nfe;
      if (rst) begin
         mq.delete();
         m_in = 0; m_dir = 0; m_pout = '0;
         m_v = 0; m_ov = 0; m_fe = 0;
         return;
      end
      nv  = m_v && !out_ready;
      nov = clr_flags ? 1'b0 : m_ov;
      nfe = clr_flags ? 1'b0 : m_fe;
      if (serial_valid && frame_start) begin
         if (m_in) nfe = 1;
         mq.delete();
         mq.push_back(serial_in);
         m_dir = dir;
         m_in = 1;
      end else if (serial_valid && m_in) begin
         mq.push_back(serial_in);
         if (mq.size() == W) begin
            m_in = 0;
            if (m_v && !out_ready) begin
               nov = 1;
            end else begin
               m_pout = assemble(m_dir);
               nv = 1;
            end
            mq.delete();
         end
      end
      m_v = nv; m_ov = nov; m_fe = nfe;
   endtask

   task automatic step(input logic sv, input logic sin, input logic fs,
                       input logic d, input logic rdy, input logic clr,
                       input logic r);
      serial_valid = sv; serial_in = sin; frame_start = fs;
      dir = d; out_ready = rdy; clr_flags = clr; rst = r;
      @(posedge clk);
      model_edge();
      #1;
      chk("parallel_out", parallel_out, m_pout);
      chk("out_valid", {7'd0, out_valid}, {7'd0, m_v});
      chk("busy", {7'd0, busy}, {7'd0, m_in});
      chk("overrun", {7'd0, overrun}, {7'd0, m_ov});
      chk("frame_err", {7'd0, frame_err}, {7'd0, m_fe});
   endtask

   task automatic idle(input logic rdy);
      step(0, 0, 0, 0, rdy, 0, 0);
   endtask

   task automatic send_word(input logic [W-1:0] w, input logic d,
                            input logic rdy, input logic rdy_last);
      for (int i = 0; i < W; i++)
         step(1, d ? w[i] : w[W-1-i], i == 0, d,
              (i == W-1) ? rdy_last : rdy, 0, 0);
   endtask

   initial begin
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("reset_pout", parallel_out, 8'h00);
      chk("reset_valid", {7'd0, out_valid}, 8'h00);

      // MSB-first A5: valid one cycle after the last bit, for one cycle
      send_word(8'hA5, 0, 1, 1);
      chk("msb_a5", parallel_out, 8'hA5);
      chk("msb_a5_v", {7'd0, out_valid}, 8'h01);
      idle(1);
      chk("msb_a5_v1", {7'd0, out_valid}, 8'h00);

      // LSB-first 3C then 81 with no gap
      send_word(8'h3C, 1, 1, 1);
      chk("lsb_3c", parallel_out, 8'h3C);
      send_word(8'h81, 1, 1, 1);
      chk("lsb_81", parallel_out, 8'h81);
      idle(1);

      // Stall of 3 cycles after bit 4
      for (int i = 0; i < 4; i++)
         step(1, (8'hA5 >> (7 - i)) & 1, i == 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("stall_busy", {7'd0, busy}, 8'h01);
      end
      for (int i = 4; i < 8; i++)
         step(1, (8'hA5 >> (7 - i)) & 1, 0, 0, 1, 0, 0);
      chk("stall_a5", parallel_out, 8'hA5);
      idle(1);

      // Backpressure / overrun
      send_word(8'h11, 0, 0, 0);
      send_word(8'h22, 0, 0, 0);
      chk("ovr_hold", parallel_out, 8'h11);
      chk("ovr_flag", {7'd0, overrun}, 8'h01);
      idle(1);
      chk("ovr_drain", {7'd0, out_valid}, 8'h00);
      step(0, 0, 0, 0, 0, 1, 0);
      chk("ovr_clr", {7'd0, overrun}, 8'h00);

      // Restart mid-frame, then completion + transfer on one edge
      for (int i = 0; i < 4; i++)
         step(1, 1'b0, i == 0, 0, 0, 0, 0);
      send_word(8'hFF, 0, 0, 0);
      chk("restart_ferr", {7'd0, frame_err}, 8'h01);
      chk("restart_ff", parallel_out, 8'hFF);
      send_word(8'h0F, 0, 0, 1);
      chk("simul_0f", parallel_out, 8'h0F);
      chk("simul_v", {7'd0, out_valid}, 8'h01);
      chk("simul_ovr", {7'd0, overrun}, 8'h00);
      step(0, 0, 0, 0, 1, 1, 0);

      // Reset mid-frame
      for (int i = 0; i < 5; i++)
         step(1, 1'b1, i == 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("rst_pout", parallel_out, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'h00);
      send_word(8'h5A, 0, 1, 1);
      chk("rst_5a", parallel_out, 8'h5A);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         logic sv, fs;
         sv = ($urandom_range(0, 3) != 0);
         fs = m_in ? ($urandom_range(0, 24) == 0)
                   : ($urandom_range(0, 1) == 1);
         step(sv, 1'($urandom), fs, 1'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              $urandom_range(0, 299) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
